// File: rtl/riscv_instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit machine words through an
// elastic two-stage valid/ready pipeline, tagging each word with a running address.
module riscv_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  input  logic             addr_load,
  input  logic [31:0]      addr_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [CNT_W-1:0] emit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);
  localparam logic [6:0]       OPC_LUI    = 7'b0110111;
  localparam logic [6:0]       OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]       OPC_JAL    = 7'b1101111;
  localparam logic [6:0]       OPC_JALR   = 7'b1100111;
  localparam logic [6:0]       OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]       OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]       OPC_STORE  = 7'b0100011;
  localparam logic [6:0]       OPC_IMM    = 7'b0010011;
  localparam logic [6:0]       OPC_OP     = 7'b0110011;
  localparam logic [31:0]      NOP        = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        s1_valid;
  logic        s1_err;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;

  logic        s1_advance;
  logic        s2_advance;
  logic        out_fire;
  logic        in_err;
  logic        in_shift;
  logic        s1_shift;
  logic        i_bad;
  logic        b_bad;
  logic        j_bad;
  logic [31:0] enc;

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = s2_advance || !s1_valid;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_fire   = out_valid && out_ready;
  assign busy       = s1_valid || out_valid;

  // Range checks: the bits above the encodable field must be a pure sign extension.
  assign i_bad    = !((&in_imm[31:11]) || !(|in_imm[31:11]));
  assign b_bad    = !((&in_imm[31:12]) || !(|in_imm[31:12]));
  assign j_bad    = !((&in_imm[31:20]) || !(|in_imm[31:20]));
  assign in_shift = (in_opcode == OPC_IMM) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
  assign s1_shift = (s1_op == OPC_IMM) && ((s1_f3 == 3'b001) || (s1_f3 == 3'b101));

  always_comb begin
    in_err = 1'b1;
    case (in_opcode)
      OPC_OP:                        in_err = 1'b0;
      OPC_IMM:                       in_err = in_shift ? (|in_imm[31:5]) : i_bad;
      OPC_LOAD, OPC_JALR, OPC_STORE: in_err = i_bad;
      OPC_BRANCH:                    in_err = b_bad || in_imm[0];
      OPC_LUI, OPC_AUIPC:            in_err = |in_imm[11:0];
      OPC_JAL:                       in_err = j_bad || in_imm[0];
      default:                       in_err = 1'b1;
    endcase
  end

  always_comb begin
    enc = NOP;
    case (s1_op)
      OPC_OP:
        enc = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
      OPC_IMM:
        enc = s1_shift ? {s1_f7, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_op}
                       : {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
      OPC_LOAD, OPC_JALR:
        enc = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
      OPC_STORE:
        enc = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
      OPC_BRANCH:
        enc = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1], s1_imm[11], s1_op};
      OPC_LUI, OPC_AUIPC:
        enc = {s1_imm[31:12], s1_rd, s1_op};
      OPC_JAL:
        enc = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
      default:
        enc = NOP;
    endcase
    if (s1_err) enc = NOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_f3    <= '0;
      s1_f7    <= '0;
      s1_imm   <= '0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_err <= in_err;
        s1_op  <= in_opcode;
        s1_rd  <= in_rd;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_f3  <= in_funct3;
        s1_f7  <= in_funct7;
        s1_imm <= in_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= NOP;
      out_err   <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= enc;
        out_err   <= s1_err;
      end
    end
  end

  // A load can never coincide with a handoff: handoff implies the pipeline is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr <= BASE_ADDR;
    end else if (addr_load && !busy) begin
      out_addr <= addr_value;
    end else if (out_fire) begin
      out_addr <= out_addr + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emit_count <= '0;
      err_count  <= '0;
    end else if (out_fire) begin
      if (emit_count != '1) emit_count <= emit_count + CNT_ONE;
      if (out_err && (err_count != '1)) err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Self-checking bench for riscv_instr_encoder: directed spec vectors plus randomized traffic
// scored against an arithmetic reference encoder.
module tb_riscv_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned CW   = 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fields_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          addr_load = 1'b0;
  logic [31:0]   addr_value = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic [31:0]   out_addr;
  logic          out_err;
  logic [CW-1:0] emit_count;
  logic [CW-1:0] err_count;
  logic          busy;

  int          checks = 0;
  int          fails  = 0;
  logic [32:0] exp_q[$];
  logic [31:0] addr_m;
  int unsigned emit_m;
  int unsigned err_m;

  always #5 clk = ~clk;

  riscv_instr_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_load(addr_load), .addr_value(addr_value), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .emit_count(emit_count), .err_count(err_count), .busy(busy)
  );

  // Reference encoder: range rules as signed-integer bounds, fields placed by shifts.
  function automatic logic [32:0] ref_encode(input fields_t f);
    logic [31:0] u, w, op, rd, rs1, rs2, f3, f7;
    longint      v;
    bit          ok;
    u = f.imm; v = longint'($signed(f.imm));
    op = 32'(f.op); rd = 32'(f.rd); rs1 = 32'(f.rs1); rs2 = 32'(f.rs2);
    f3 = 32'(f.f3); f7 = 32'(f.f7);
    ok = 1'b1; w = '0;
    case (f.op)
      7'h33: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      7'h13: begin
        if (f.f3 == 3'd1 || f.f3 == 3'd5) begin
          ok = (u < 32);
          w  = (f7 << 25) | (u << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        end else begin
          ok = (v >= -2048) && (v <= 2047);
          w  = ((u % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        end
      end
      7'h03, 7'h67: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = ((u % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      7'h23: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = (((u / 32) % 128) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((u % 32) << 7) | op;
      end
      7'h63: begin
        ok = (v >= -4096) && (v <= 4095) && (u % 2 == 0);
        w  = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (rs2 << 20) | (rs1 << 15)
           | (f3 << 12) | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7) | op;
      end
      7'h37, 7'h17: begin
        ok = (u % 4096 == 0);
        w  = u | (rd << 7) | op;
      end
      7'h6F: begin
        ok = (v >= -1048576) && (v <= 1048575) && (u % 2 == 0);
        w  = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21) | (((u / 2048) % 2) << 20)
           | (((u / 4096) % 256) << 12) | (rd << 7) | op;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, NOP};
    return {1'b0, w};
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
    f.f3 = 3'($urandom); f.f7 = 7'($urandom);
    case ($urandom_range(0, 9))
      0: f.op = 7'h37;  1: f.op = 7'h17;  2: f.op = 7'h6F;  3: f.op = 7'h67;
      4: f.op = 7'h63;  5: f.op = 7'h03;  6: f.op = 7'h23;  7: f.op = 7'h13;
      8: f.op = 7'h33;  default: f.op = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0: f.imm = $urandom;
      1: f.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: f.imm = $urandom & 32'hFFFF_F000;
      3: f.imm = 32'($urandom_range(0, 63));
      default: f.imm = ($urandom_range(0, 1) != 0 ? 32'hFFE0_0000 : 32'h0) | ($urandom & 32'h001F_FFFF);
    endcase
    return f;
  endfunction

  task automatic set_fields(input fields_t f);
    in_opcode = f.op; in_rd = f.rd; in_rs1 = f.rs1; in_rs2 = f.rs2;
    in_funct3 = f.f3; in_funct7 = f.f7; in_imm = f.imm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_value = '0;
    set_fields('0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete(); addr_m = BASE; emit_m = 0; err_m = 0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_instr !== NOP) begin fails++; $display("FAIL reset_out_instr: got %h want %h", out_instr, NOP); end
    checks++; if (out_err !== 1'b0) begin fails++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    checks++; if (out_addr !== BASE) begin fails++; $display("FAIL reset_out_addr: got %h want %h", out_addr, BASE); end
    checks++; if (emit_count !== '0) begin fails++; $display("FAIL reset_emit_count: got %0d want 0", emit_count); end
    checks++; if (err_count !== '0) begin fails++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    do_reset();
    set_fields('{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF});
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL addi_accept: in_ready %b want 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_latency_early: out_valid %b want 0", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF1_0093 || out_err !== 1'b0 || out_addr !== 32'h0) begin
      fails++;
      $display("FAIL addi_word: valid %b instr %h err %b addr %h want 1 fff10093 0 00000000",
               out_valid, out_instr, out_err, out_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    fields_t     w[4];
    logic [31:0] exp_w[4];
    w[0] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0};           exp_w[0] = 32'h0020_81B3;
    w[1] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8};           exp_w[1] = 32'h0020_8463;
    w[2] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048};        exp_w[2] = 32'h0010_00EF;
    w[3] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000};   exp_w[3] = 32'h1234_52B7;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin set_fields(w[c]); in_valid = 1'b1; end else in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== (c >= 2 && c < 6)) begin
        fails++; $display("FAIL b2b_valid cycle %0d: got %b", c, out_valid);
      end else if (out_valid) begin
        checks++;
        if (out_instr !== exp_w[c-2] || out_err !== 1'b0 || out_addr !== 32'(4 * (c - 2))) begin
          fails++;
          $display("FAIL b2b_word %0d: instr %h err %b addr %h want %h 0 %h",
                   c - 2, out_instr, out_err, out_addr, exp_w[c-2], 32'(4 * (c - 2)));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_errors();
    fields_t w[3];
    w[0] = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048};
    w[1] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7};
    w[2] = '{7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin set_fields(w[c]); in_valid = 1'b1; end else in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== (c >= 2 && c < 5)) begin
        fails++; $display("FAIL err_valid cycle %0d: got %b", c, out_valid);
      end else if (out_valid) begin
        checks++;
        if (out_instr !== NOP || out_err !== 1'b1) begin
          fails++; $display("FAIL err_word %0d: instr %h err %b want %h 1", c - 2, out_instr, out_err, NOP);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (err_count !== CW'(3) || emit_count !== CW'(3)) begin
      fails++; $display("FAIL err_counts: err %0d emit %0d want 3 3", err_count, emit_count);
    end
  endtask

  task automatic test_backpressure();
    fields_t     f;
    logic [32:0] e;
    logic [31:0] held;
    int unsigned acc, outs;
    do_reset();
    out_ready = 1'b0; acc = 0; held = '0;
    for (int c = 0; c < 6; c++) begin
      f = '{7'h13, 5'(c + 1), 5'(c), 5'd0, 3'd0, 7'd0, 32'(c * 3)};
      set_fields(f); in_valid = 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin acc++; exp_q.push_back(ref_encode(f)); end
      if (c == 3) held = out_instr;
      if (c > 3) begin
        checks++;
        if (out_instr !== held || out_valid !== 1'b1) begin
          fails++; $display("FAIL bp_stall_hold: instr %h valid %b want %h 1", out_instr, out_valid, held);
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (acc != 2) begin fails++; $display("FAIL bp_accepts: got %0d want 2", acc); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1; outs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        outs++; checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL bp_extra_word: got %h want none", out_instr);
        end else begin
          e = exp_q.pop_front();
          if ({out_err, out_instr} !== e) begin
            fails++; $display("FAIL bp_order: got %b %h want %b %h", out_err, out_instr, e[32], e[31:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (outs != 2 || exp_q.size() != 0) begin
      fails++; $display("FAIL bp_drain: emitted %0d pending %0d want 2 0", outs, exp_q.size());
    end
  endtask

  task automatic test_addr();
    bit ok;
    do_reset();
    set_fields('{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1});
    addr_load = 1'b1; addr_value = 32'h100;
    @(posedge clk); #1 addr_load = 1'b0;
    @(negedge clk);
    checks++; if (out_addr !== 32'h100) begin fails++; $display("FAIL addr_load_idle: got %h want 00000100", out_addr); end
    @(posedge clk); #1 in_valid = 1'b1;
    @(posedge clk); #1 in_rd = 5'd2;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(ok);
    checks++; if (!ok || out_addr !== 32'h100) begin fails++; $display("FAIL addr_word0: ok %b addr %h want 1 00000100", ok, out_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_addr !== 32'h104) begin fails++; $display("FAIL addr_word1: valid %b addr %h want 1 00000104", out_valid, out_addr); end
    @(posedge clk); #1 in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; addr_load = 1'b1; addr_value = 32'h500;
    @(posedge clk); #1 addr_load = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_addr !== 32'h108) begin fails++; $display("FAIL addr_busy_ignore: valid %b addr %h want 1 00000108", out_valid, out_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_addr !== 32'h10C) begin fails++; $display("FAIL addr_after_ignore: got %h want 0000010c", out_addr); end
    @(posedge clk); #1 addr_load = 1'b1; addr_value = 32'h200; in_valid = 1'b1;
    @(posedge clk); #1 addr_load = 1'b0; in_valid = 1'b0;
    wait_out(ok);
    checks++; if (!ok || out_addr !== 32'h200) begin fails++; $display("FAIL addr_load_with_valid: ok %b addr %h want 1 00000200", ok, out_addr); end
    @(posedge clk); #1 addr_load = 1'b1; addr_value = 32'hFFFF_FFFC;
    @(posedge clk); #1 addr_load = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(ok);
    checks++; if (!ok || out_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL addr_top: ok %b addr %h want 1 fffffffc", ok, out_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_addr !== 32'h0 || out_valid !== 1'b0) begin fails++; $display("FAIL addr_wrap: addr %h valid %b want 00000000 0", out_addr, out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    fields_t     f;
    logic [32:0] e;
    logic [31:0] h_instr, h_addr;
    logic        h_err;
    bit          stalled;
    do_reset();
    stalled = 1'b0; h_instr = '0; h_addr = '0; h_err = 1'b0;
    for (int c = 0; c < 600; c++) begin
      f = rand_fields();
      set_fields(f);
      in_valid  = (c < 560) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 560) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_instr !== h_instr || out_addr !== h_addr || out_err !== h_err) begin
          fails++; $display("FAIL rand_stall_hold cycle %0d: valid %b instr %h addr %h want 1 %h %h",
                            c, out_valid, out_instr, out_addr, h_instr, h_addr);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rand_extra_word cycle %0d: got %h want none", c, out_instr);
        end else begin
          e = exp_q.pop_front();
          if ({out_err, out_instr} !== e || out_addr !== addr_m) begin
            fails++; $display("FAIL rand_word cycle %0d: err %b instr %h addr %h want %b %h %h",
                              c, out_err, out_instr, out_addr, e[32], e[31:0], addr_m);
          end
          if (e[32] && err_m < 15) err_m++;
        end
        addr_m = addr_m + 32'd4;
        if (emit_m < 15) emit_m++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_encode(f));
      stalled = out_valid && !out_ready;
      h_instr = out_instr; h_addr = out_addr; h_err = out_err;
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL rand_lost_words: pending %0d want 0", exp_q.size()); end
    checks++; if (emit_count !== CW'(emit_m)) begin fails++; $display("FAIL rand_emit_count: got %0d want %0d", emit_count, emit_m); end
    checks++; if (err_count !== CW'(err_m)) begin fails++; $display("FAIL rand_err_count: got %0d want %0d", err_count, err_m); end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    set_fields('{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5});
    in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL mid_setup: busy %b valid %b want 1 1", busy, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (emit_count !== '0 || err_count !== '0) begin fails++; $display("FAIL mid_counts: emit %0d err %0d want 0 0", emit_count, err_count); end
    checks++; if (out_addr !== BASE) begin fails++; $display("FAIL mid_out_addr: got %h want %h", out_addr, BASE); end
    checks++; if (out_instr !== NOP) begin fails++; $display("FAIL mid_out_instr: got %h want %h", out_instr, NOP); end
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_dropped cycle %0d: out_valid %b want 0", c, out_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_addr();
    test_random();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
